// File: rtl/wb_bridge_128to32.sv
// ---------------------------------------------------------------------------
// wb_bridge_128to32
//
// Wishbone data-width bridge: one 128-bit crossbar slave port in, one 32-bit
// Wishbone master port out.  A wide access is split into one narrow beat per
// active 32-bit lane (lane k active when any of sel[4k+3:4k] is set), issued
// in ascending lane order.  Read data is reassembled into the matching
// 128-bit lanes and a single ack or err is returned upstream.  A per-beat
// timeout turns a hung narrow slave into an upstream error.
//
// Parameters
//   AW       address width on both sides
//   TIMEOUT  max cycles a narrow beat may wait for ack/err (0 = no timeout)
//
// Ports
//   clk, rst_n                system clock, synchronous active-low reset
//   i_wb_adr/sel/we/dat       wide request (byte address, 16 byte selects)
//   i_wb_cyc, i_wb_stb        wide cycle / strobe
//   o_wb_dat/ack/err          wide response (single-cycle ack or err)
//   o_n_adr/sel/we/dat        narrow request fields for the current lane
//   o_n_cyc, o_n_stb          narrow cycle / strobe
//   i_n_dat/ack/err           narrow response
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for a wide request; captures it and builds the lane mask
// BEAT  | narrow cyc/stb asserted for the current lane, waiting ack/err/timeout
// GAP   | one cycle with stb low and cyc held, before the next lane's beat
// RESP  | single-cycle upstream ack/err with the assembled read data
// ---------------------------------------------------------------------------
module wb_bridge_128to32 #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,

  input  logic [AW-1:0]  i_wb_adr,
  input  logic [15:0]    i_wb_sel,
  input  logic           i_wb_we,
  input  logic [127:0]   i_wb_dat,
  input  logic           i_wb_cyc,
  input  logic           i_wb_stb,
  output logic [127:0]   o_wb_dat,
  output logic           o_wb_ack,
  output logic           o_wb_err,

  output logic [AW-1:0]  o_n_adr,
  output logic [3:0]     o_n_sel,
  output logic           o_n_we,
  output logic [31:0]    o_n_dat,
  output logic           o_n_cyc,
  output logic           o_n_stb,
  input  logic [31:0]    i_n_dat,
  input  logic           i_n_ack,
  input  logic           i_n_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // Lane k is active when any of its four byte selects is set.
  function automatic logic [3:0] lane_mask(input logic [15:0] sel);
    for (int k = 0; k < 4; k++) begin
      lane_mask[k] = |sel[4*k +: 4];
    end
  endfunction

  // Lowest set bit of the remaining mask selects the next lane.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    first_lane = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) first_lane = 2'(k);
    end
  endfunction

  // Captured request and control state
  state_t          state_q, state_d;
  logic [AW-1:4]   adr_q,   adr_d;
  logic            we_q,    we_d;
  logic [15:0]     sel_q,   sel_d;
  logic [127:0]    dat_q,   dat_d;
  logic [3:0]      mask_q,  mask_d;
  logic [1:0]      lane_q,  lane_d;
  logic [127:0]    rbuf_q,  rbuf_d;
  logic [TW-1:0]   cnt_q,   cnt_d;
  logic            err_q,   err_d;
  logic            abort_q, abort_d;

  // Registered outputs
  logic [127:0]    wb_dat_q, wb_dat_d;
  logic            wb_ack_q, wb_ack_d;
  logic            wb_err_q, wb_err_d;
  logic [AW-1:0]   n_adr_q,  n_adr_d;
  logic [3:0]      n_sel_q,  n_sel_d;
  logic            n_we_q,   n_we_d;
  logic [31:0]     n_dat_q,  n_dat_d;
  logic            n_cyc_q,  n_cyc_d;
  logic            n_stb_q,  n_stb_d;

  // Scratch signals of the next-state logic
  logic [3:0]      req_mask;
  logic [3:0]      mask_left;
  logic [1:0]      nxt_lane;
  logic            beat_fail;
  logic            timeout_hit;

  // Byte offset within the 128-bit word is implied by the lane selects.
  logic [3:0]      unused_adr_lsb;
  assign unused_adr_lsb = i_wb_adr[3:0];

  // Fires on the TIMEOUT-th BEAT cycle of the current lane.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    mask_d    = mask_q;
    lane_d    = lane_q;
    rbuf_d    = rbuf_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    abort_d   = abort_q;

    wb_dat_d  = wb_dat_q;
    wb_ack_d  = 1'b0;
    wb_err_d  = 1'b0;
    n_adr_d   = n_adr_q;
    n_sel_d   = n_sel_q;
    n_we_d    = n_we_q;
    n_dat_d   = n_dat_q;
    n_cyc_d   = n_cyc_q;
    n_stb_d   = n_stb_q;

    req_mask  = lane_mask(i_wb_sel);
    mask_left = mask_q;
    nxt_lane  = 2'd0;
    beat_fail = 1'b0;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        err_d   = 1'b0;
        if (i_wb_cyc && i_wb_stb) begin
          adr_d  = i_wb_adr[AW-1:4];
          we_d   = i_wb_we;
          sel_d  = i_wb_sel;
          dat_d  = i_wb_dat;
          mask_d = req_mask;
          rbuf_d = '0;
          cnt_d  = '0;
          if (req_mask == 4'h0) begin
            // Nothing to transfer: acknowledge straight away with zero data.
            state_d  = RESP;
            wb_ack_d = 1'b1;
            wb_dat_d = '0;
          end else begin
            nxt_lane = first_lane(req_mask);
            lane_d   = nxt_lane;
            state_d  = BEAT;
            n_adr_d  = {i_wb_adr[AW-1:4], nxt_lane, 2'b00};
            n_sel_d  = i_wb_sel[{nxt_lane, 2'b00} +: 4];
            n_dat_d  = i_wb_dat[{nxt_lane, 5'd0} +: 32];
            n_we_d   = i_wb_we;
            n_cyc_d  = 1'b1;
            n_stb_d  = 1'b1;
          end
        end
      end

      BEAT: begin
        // Once the master drops cyc, the transaction is abandoned after the
        // beat in flight; remember it even if cyc comes back.
        abort_d   = abort_q | ~i_wb_cyc;
        // err has priority over a simultaneous ack; a timeout counts as err.
        beat_fail = i_n_err | (~i_n_ack & timeout_hit);
        if (beat_fail || i_n_ack) begin
          mask_left = mask_q & ~(4'b0001 << lane_q);
          n_stb_d   = 1'b0;
          if (!we_q && !beat_fail) begin
            rbuf_d[{lane_q, 5'd0} +: 32] = i_n_dat;
          end
          if (beat_fail) begin
            err_d = 1'b1;
          end
          if (abort_d) begin
            state_d = IDLE;
            n_cyc_d = 1'b0;
            mask_d  = 4'h0;
          end else if (beat_fail) begin
            state_d  = RESP;
            n_cyc_d  = 1'b0;
            mask_d   = 4'h0;
            wb_err_d = 1'b1;
            wb_dat_d = rbuf_q;
          end else if (mask_left != 4'h0) begin
            state_d = GAP;
            mask_d  = mask_left;
          end else begin
            state_d  = RESP;
            n_cyc_d  = 1'b0;
            mask_d   = 4'h0;
            wb_ack_d = 1'b1;
            wb_dat_d = rbuf_d;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      GAP: begin
        abort_d = abort_q | ~i_wb_cyc;
        if (abort_d) begin
          state_d = IDLE;
          n_cyc_d = 1'b0;
          mask_d  = 4'h0;
        end else begin
          nxt_lane = first_lane(mask_q);
          lane_d   = nxt_lane;
          state_d  = BEAT;
          cnt_d    = '0;
          n_adr_d  = {adr_q, nxt_lane, 2'b00};
          n_sel_d  = sel_q[{nxt_lane, 2'b00} +: 4];
          n_dat_d  = dat_q[{nxt_lane, 5'd0} +: 32];
          n_stb_d  = 1'b1;
        end
      end

      RESP: begin
        state_d  = IDLE;
        err_d    = 1'b0;
        wb_dat_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
      mask_q   <= '0;
      lane_q   <= '0;
      rbuf_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      wb_dat_q <= '0;
      wb_ack_q <= 1'b0;
      wb_err_q <= 1'b0;
      n_adr_q  <= '0;
      n_sel_q  <= '0;
      n_we_q   <= 1'b0;
      n_dat_q  <= '0;
      n_cyc_q  <= 1'b0;
      n_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      mask_q   <= mask_d;
      lane_q   <= lane_d;
      rbuf_q   <= rbuf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      wb_dat_q <= wb_dat_d;
      wb_ack_q <= wb_ack_d;
      wb_err_q <= wb_err_d;
      n_adr_q  <= n_adr_d;
      n_sel_q  <= n_sel_d;
      n_we_q   <= n_we_d;
      n_dat_q  <= n_dat_d;
      n_cyc_q  <= n_cyc_d;
      n_stb_q  <= n_stb_d;
    end
  end

  assign o_wb_dat = wb_dat_q;
  assign o_wb_ack = wb_ack_q;
  assign o_wb_err = wb_err_q;
  assign o_n_adr  = n_adr_q;
  assign o_n_sel  = n_sel_q;
  assign o_n_we   = n_we_q;
  assign o_n_dat  = n_dat_q;
  assign o_n_cyc  = n_cyc_q;
  assign o_n_stb  = n_stb_q;

endmodule

// File: doc/wb_bridge_128to32.md
Name: wb_bridge_128to32

Overview:
- Wishbone data-width bridge between one 128-bit crossbar slave port and one 32-bit Wishbone slave (e.g. UART, GPIO, timer).
- Splits each wide access into one narrow beat per active 32-bit lane, in ascending lane order.
- Reassembles read data into the correct 128-bit lanes, then returns a single ack/err upstream.
- Includes a per-beat timeout so that a hung narrow slave cannot stall the core.

Parameters:
- AW, 32, address width on both sides.
- TIMEOUT, 255, maximum wait cycles per narrow beat before error. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- i_wb_adr  in  AW  wide-side address (byte address).
- i_wb_sel  in  16  wide byte selects.
- i_wb_we  in  1  write enable.
- i_wb_dat  in  128  wide write data.
- i_wb_cyc  in  1  cycle.
- i_wb_stb  in  1  strobe.
- o_wb_dat  out  128  wide read data.
- o_wb_ack  out  1  wide acknowledge.
- o_wb_err  out  1  wide error.
- o_n_adr  out  AW  narrow address.
- o_n_sel  out  4  narrow byte selects.
- o_n_we  out  1  narrow write enable.
- o_n_dat  out  32  narrow write data.
- o_n_cyc  out  1  narrow cycle.
- o_n_stb  out  1  narrow strobe.
- i_n_dat  in  32  narrow read data.
- i_n_ack  in  1  narrow acknowledge.
- i_n_err  in  1  narrow error.

Behaviour:
- Reset: all outputs registered and 0; FSM=IDLE; lane mask, read buffer, timeout counter and error flag cleared.
- Lane k (0..3) is active iff |i_wb_sel[4k+3:4k].
- Lane k maps to:
  - narrow address {i_wb_adr[AW-1:4], k[1:0], 2'b00}
  - narrow sel i_wb_sel[4k+3:4k]
  - narrow write data i_wb_dat[32k+31:32k]
- FSM states: IDLE, BEAT, GAP, RESP.
- IDLE:
  - On i_wb_cyc&i_wb_stb, capture adr/we/dat/sel, build the lane mask and clear the read buffer.
  - If the mask is 0, go to RESP with ack and zero data.
  - Otherwise go to BEAT on the lowest active lane.
- BEAT:
  - o_n_cyc=o_n_stb=1 with the current lane's fields; the timeout counter increments each cycle.
  - On i_n_ack: for reads, store i_n_dat into buffer lane k. Clear mask bit k. Go to GAP if lanes remain, else RESP.
  - On i_n_err: set the error flag, discard remaining lanes, go to RESP.
  - If i_n_ack and i_n_err occur together, err wins.
  - Timeout: counter reaching TIMEOUT without ack/err (TIMEOUT!=0) is treated as i_n_err; the narrow cycle is dropped.
- GAP:
  - Exactly one cycle with o_n_stb=0 and o_n_cyc held 1. This satisfies slaves that generate ack from stb&~ack.
  - Then go to BEAT on the next active lane; the counter is cleared.
- RESP:
  - o_n_cyc=0.
  - Exactly one cycle of o_wb_ack (or o_wb_err if the flag is set; never both).
  - o_wb_dat = assembled buffer. Unaccessed lanes read 0; writes return all 0.
  - Then go to IDLE; the flag is cleared.
- Upstream abort (i_wb_cyc low while in BEAT/GAP):
  - The current narrow beat completes (ack/err/timeout).
  - Remaining lanes are dropped and the FSM returns to IDLE with no upstream ack/err.
- Throughput:
  - Latency with a zero-wait narrow slave is request sampled at edge 0, o_n_stb in cycle 1, o_wb_ack in cycle 2.
  - Each extra lane adds 2 cycles (GAP + BEAT).
  - A new request is accepted in the first IDLE cycle after RESP.
- Synchronous reset mid-transaction forces IDLE next edge, deasserts o_n_cyc/o_n_stb and suppresses any pending upstream ack.

Test Plan:
- Read, sel=16'h00F0, adr=0x0100_0010, narrow slave returns 0xDEADBEEF with zero wait:
  - o_n_adr=0x0100_0014, o_n_sel=4'hF.
  - o_wb_ack 2 cycles after request.
  - o_wb_dat=128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000.
- Write, sel=16'hFFFF, dat=128'h44444444_33333333_22222222_11111111:
  - Four beats at offsets 0x0, 0x4, 0x8, 0xC, data 0x11111111..0x44444444 in order.
  - One GAP cycle between beats.
  - Single o_wb_ack after the 4th narrow ack.
- Read, sel=16'hF00F, narrow slave asserts i_n_err on lane 0:
  - Lane 3 is never issued.
  - o_wb_err for one cycle; o_wb_ack stays 0.
- TIMEOUT=8, slave never acks:
  - o_n_stb drops after 8 BEAT cycles.
  - o_wb_err pulses once.
  - The next request is serviced normally.
- Edge cases:
  - sel=16'h0000 → o_wb_ack next cycle, o_n_cyc never asserted.
  - rst_n low during lane-2 BEAT of a 4-lane write → outputs 0 next edge and no o_wb_ack.
